softmax_input_packer: RTL and testbench

//  Producer side of the softmax wide-bus interface. Accepts a narrow beat stream of

---
 rtl/softmax_pkg.sv | 31 +++
 rtl/packer_beat_counter.sv | 31 +++
 rtl/softmax_input_packer.sv | 87 ++++++++
 tb/tb_softmax_input_packer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax wide-bus producer: FSM encoding and
// helpers that size the beat counter and the flat tensor bus.
package softmax_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } pack_state_t;

  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_MATRIX_NUM    = 12;
  localparam int DEF_INPUT_SHAPE_1 = 128;
  localparam int DEF_INPUT_SHAPE_2 = 128;
  localparam int DEF_LANES         = 16;

  // Width of the flat tensor bus for the default geometry.
  localparam int DEF_FLAT_W =
    DEF_DATA_WIDTH * DEF_MATRIX_NUM * DEF_INPUT_SHAPE_1 * DEF_INPUT_SHAPE_2;

  function automatic int beats_per_frame(input int matrix_num, input int shape_1,
                                         input int shape_2, input int lanes);
    return (matrix_num * shape_1 * shape_2) / lanes;
  endfunction

  function automatic int flat_width(input int data_width, input int matrix_num,
                                    input int shape_1, input int shape_2);
    return data_width * matrix_num * shape_1 * shape_2;
  endfunction

endpackage

// File: rtl/packer_beat_counter.sv
// Modulo-BEATS beat index with increment and synchronous clear; raises
// terminal while the index sits on the last beat of a frame.
module packer_beat_counter #(
  parameter int BEATS = 4,
  parameter int CW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic          clk_p,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic          terminal
);

  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  assign terminal = (count == LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= terminal ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/softmax_input_packer.sv
// Assembles a narrow beat stream into the full flat softmax tensor, strobes
// output_valid_n low for one cycle per frame and holds it until consumed.
module softmax_input_packer
  import softmax_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int MATRIX_NUM    = DEF_MATRIX_NUM,
  parameter int INPUT_SHAPE_1 = DEF_INPUT_SHAPE_1,
  parameter int INPUT_SHAPE_2 = DEF_INPUT_SHAPE_2,
  parameter int LANES         = DEF_LANES
) (
  input  logic                          clk_p,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH*LANES-1:0]   in_data,
  input  logic                          in_valid_n,
  output logic                          in_ready_n,
  input  logic                          flush_n,
  output logic [flat_width(DATA_WIDTH, MATRIX_NUM, INPUT_SHAPE_1, INPUT_SHAPE_2)-1:0] matrix,
  output logic                          output_valid_n,
  input  logic                          consume_done_n
);

  localparam int BEAT_W = DATA_WIDTH * LANES;
  localparam int BEATS  = beats_per_frame(MATRIX_NUM, INPUT_SHAPE_1, INPUT_SHAPE_2, LANES);
  localparam int CW     = (BEATS > 1) ? $clog2(BEATS) : 1;

  pack_state_t   state, state_next;
  logic [CW-1:0] count;
  logic          terminal;
  logic          accept;
  logic          flush;
  logic          done;

  assign flush      = !flush_n;
  assign done       = !consume_done_n;
  assign in_ready_n = (state != ST_FILL);
  assign accept     = !in_valid_n && !in_ready_n && !flush;

  packer_beat_counter #(
    .BEATS (BEATS),
    .CW    (CW)
  ) u_beat_counter (
    .clk_p    (clk_p),
    .rst_n    (rst_n),
    .inc      (accept),
    .clear    (flush),
    .count    (count),
    .terminal (terminal)
  );

  // NOTE: the default assignment before the case keeps every path driven, so
  // this block never infers a latch.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = ST_FILL;
    end else begin
      case (state)
        ST_FILL:  if (accept && terminal) state_next = ST_ISSUE;
        ST_ISSUE: state_next = done ? ST_FILL : ST_WAIT;
        ST_WAIT:  if (done) state_next = ST_FILL;
        default:  state_next = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_FILL;
      output_valid_n <= 1'b1;
    end else begin
      state          <= state_next;
      output_valid_n <= (state_next != ST_ISSUE);
    end
  end

  // NOTE: the tensor register is wide, but downstream relies on a zero tensor
  // after reset, so it is reset rather than left uninitialised.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      matrix <= '0;
    end else if (accept) begin
      matrix[BEAT_W*int'(count) +: BEAT_W] <= in_data;
    end
  end

endmodule

// File: tb/tb_softmax_input_packer.sv
// Directed plus randomized bench for softmax_input_packer on a 2x2x4 tensor
// with 4 lanes, compared against an element-level reference model.
module tb_softmax_input_packer;

  localparam int DW = 8;
  localparam int M  = 2;
  localparam int R  = 2;
  localparam int C  = 4;
  localparam int L  = 4;
  localparam int NB = M * R * C / L;
  localparam int FW = DW * M * R * C;

  logic            clk_p = 1'b0;
  logic            rst_n = 1'b0;
  logic [DW*L-1:0] in_data = '0;
  logic            in_valid_n = 1'b1;
  logic            in_ready_n;
  logic            flush_n = 1'b1;
  logic [FW-1:0]   matrix;
  logic            output_valid_n;
  logic            consume_done_n = 1'b1;

  int total = 0;
  int bad   = 0;

  softmax_input_packer #(
    .DATA_WIDTH(DW), .MATRIX_NUM(M), .INPUT_SHAPE_1(R), .INPUT_SHAPE_2(C), .LANES(L)
  ) dut (
    .clk_p          (clk_p),
    .rst_n          (rst_n),
    .in_data        (in_data),
    .in_valid_n     (in_valid_n),
    .in_ready_n     (in_ready_n),
    .flush_n        (flush_n),
    .matrix         (matrix),
    .output_valid_n (output_valid_n),
    .consume_done_n (consume_done_n)
  );

  always #5 clk_p = ~clk_p;

  // Reference: tensor elements by (matrix,row,col), beats taken this frame,
  // whether a full frame is being held, and whether the strobe is showing.
  logic [DW-1:0] elem [M][R][C];
  int            m_beats;
  bit            m_busy;
  bit            m_strobe;

  function automatic void model_reset();
    for (int m = 0; m < M; m++)
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) elem[m][r][c] = '0;
    m_beats  = 0;
    m_busy   = 0;
    m_strobe = 0;
  endfunction

  function automatic void model_step(bit v, logic [DW*L-1:0] d, bit fl, bit dn);
    if (fl) begin
      m_beats  = 0;
      m_busy   = 0;
      m_strobe = 0;
    end else if (!m_busy) begin
      m_strobe = 0;
      if (v) begin
        for (int k = 0; k < L; k++) begin
          int e = m_beats * L + k;
          elem[e / (R*C)][(e / C) % R][e % C] = d[k*DW +: DW];
        end
        m_beats++;
        if (m_beats == NB) begin
          m_beats  = 0;
          m_busy   = 1;
          m_strobe = 1;
        end
      end
    end else begin
      m_strobe = 0;
      if (dn) m_busy = 0;
    end
  endfunction

  function automatic logic [FW-1:0] model_matrix();
    logic [FW-1:0] v = '0;
    for (int m = 0; m < M; m++)
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) v[((m*R + r)*C + c)*DW +: DW] = elem[m][r][c];
    return v;
  endfunction

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ready_n"}, FW'(in_ready_n), FW'(!m_busy ? 1'b0 : 1'b1));
    check({tag, ".valid_n"}, FW'(output_valid_n), FW'(!m_strobe));
    check({tag, ".matrix"}, matrix, model_matrix());
  endtask

  // One clock: drive inputs, clock, advance model, sample 1 time unit later.
  task automatic tick(input bit v, input logic [DW*L-1:0] d, input bit fl, input bit dn,
                      input string tag);
    in_valid_n     = !v;
    in_data        = d;
    flush_n        = !fl;
    consume_done_n = !dn;
    @(posedge clk_p);
    model_step(v, d, fl, dn);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(0, '0, 0, 0, tag);
  endtask

  initial begin
    bit gaps [6] = '{1, 0, 1, 1, 0, 1};
    logic [FW-1:0] snap;

    // 1. reset state, then idle with no strobe
    model_reset();
    repeat (2) @(posedge clk_p);
    #1;
    check_all("reset");
    check("reset.zero", matrix, '0);
    @(negedge clk_p);
    rst_n = 1'b1;
    idle(3, "idle");

    // 2. four back-to-back beats with known data
    tick(1, 32'h03020100, 0, 0, "b2.0");
    tick(1, 32'h07060504, 0, 0, "b2.1");
    tick(1, 32'h0B0A0908, 0, 0, "b2.2");
    tick(1, 32'h0F0E0D0C, 0, 0, "b2.3");
    check("b2.const", matrix, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
    check("b2.strobe", FW'(output_valid_n), '0);
    check("b2.busy", FW'(in_ready_n), FW'(1));

    // 3. beats offered while holding are not taken; consume releases
    snap = matrix;
    for (int i = 0; i < 5; i++) tick(1, $urandom, 0, 0, "b3.hold");
    check("b3.unchanged", matrix, snap);
    tick(0, '0, 0, 1, "b3.done");
    check("b3.ready", FW'(in_ready_n), '0);

    // 4. valid gaps; strobe only after the fourth accepted beat
    foreach (gaps[i]) tick(gaps[i], $urandom, 0, 0, "b4.gap");
    check("b4.strobe", FW'(output_valid_n), '0);
    tick(0, '0, 0, 1, "b4.done_in_issue");
    check("b4.fill", FW'(in_ready_n), '0);

    // 5. flush with a beat present drops it and restarts the frame
    tick(1, $urandom, 0, 0, "b5.0");
    tick(1, $urandom, 0, 0, "b5.1");
    tick(1, 32'hDEADBEEF, 1, 0, "b5.flush");
    for (int i = 0; i < NB; i++) tick(1, $urandom, 0, 0, "b5.refill");
    check("b5.strobe", FW'(output_valid_n), '0);
    tick(0, '0, 0, 1, "b5.done");

    // 6. asynchronous reset mid-frame
    for (int i = 0; i < 3; i++) tick(1, $urandom, 0, 0, "b6.pre");
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("b6.reset");
    @(negedge clk_p);
    rst_n = 1'b1;
    for (int i = 0; i < NB - 1; i++) tick(1, $urandom, 0, 0, "b6.fresh");
    check("b6.nostrobe", FW'(output_valid_n), FW'(1));
    tick(1, $urandom, 0, 0, "b6.last");
    check("b6.strobe", FW'(output_valid_n), '0);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      tick($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 19) == 0,
           $urandom_range(0, 3) == 0, "rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
